rf_wb_arbiter: RTL

Write-back front end for the core's dual-write-port register file. Two producers, ALU (source A) and LSU (source L), hand results over through valid/ready handshakes. Each source has its own small queue. Every cycle the arbiter drains up to one entry per queue onto register-file write ports A and B. It also reports pending writes to the decode stage so decode can detect hazards.

---
 rtl/rf_wb_arbiter_pkg.sv | 16 +
 rtl/rf_wb_arbiter_if.sv | 31 +++
 rtl/rf_wb_arbiter_wb_fifo.sv | 67 ++++++
 rtl/rf_wb_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// The queue entry layout is one destination register plus its data.
package rf_wb_arbiter_pkg;

    localparam int WB_AWIDTH = 5;
    localparam int WB_DWIDTH = 32;
    localparam int WB_QDEPTH = 4;

    localparam logic [WB_AWIDTH-1:0] X0_ADDR = '0;

    typedef struct packed {
        logic [WB_AWIDTH-1:0] addr;
        logic [WB_DWIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Producer-side handshake bundle for the ALU (a_*) and LSU (l_*) sources.
// The producer side is the master; the arbiter is the slave.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AWIDTH = WB_AWIDTH,
    parameter int DWIDTH = WB_DWIDTH
) ();

    logic              a_valid;
    logic              a_ready;
    logic [AWIDTH-1:0] a_addr;
    logic [DWIDTH-1:0] a_data;
    logic              l_valid;
    logic              l_ready;
    logic [AWIDTH-1:0] l_addr;
    logic [DWIDTH-1:0] l_data;

    modport master (
        output a_valid, a_addr, a_data,
        output l_valid, l_addr, l_data,
        input  a_ready, l_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  l_valid, l_addr, l_data,
        output a_ready, l_ready
    );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Per-source write-back queue; exposes per-slot valid/address so the
// arbiter can match pending writes against decode source registers.
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AWIDTH = WB_AWIDTH,
    parameter int DWIDTH = WB_DWIDTH,
    parameter int DEPTH  = WB_QDEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [AWIDTH-1:0]             in_addr,
    input  logic [DWIDTH-1:0]             in_data,
    output logic                          full,
    input  logic                          pop,
    output logic                          empty,
    output logic [AWIDTH-1:0]             head_addr,
    output logic [DWIDTH-1:0]             head_data,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][AWIDTH-1:0]  ent_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = 1;

    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic [PW:0]       count;
    logic [AWIDTH-1:0] mem_addr [DEPTH];
    logic [DWIDTH-1:0] mem_data [DEPTH];

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_addr = mem_addr[rd_ptr[PW-1:0]];
    assign head_data = mem_data[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_addr[wr_ptr[PW-1:0]] <= in_addr;
            mem_data[wr_ptr[PW-1:0]] <= in_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off          = PW'(i) - rd_ptr[PW-1:0];
        assign ent_valid[i] = ({1'b0, off} < count);
        assign ent_addr[i]  = mem_addr[i];
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Drains the ALU and LSU queues onto register-file ports A and B and
// reports pending writes to decode for hazard detection.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AWIDTH = WB_AWIDTH,
    parameter int DWIDTH = WB_DWIDTH,
    parameter int QDEPTH = WB_QDEPTH
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    bus,
    output logic [AWIDTH-1:0] wa,
    output logic              wea,
    output logic [DWIDTH-1:0] wa_data,
    output logic [AWIDTH-1:0] wb,
    output logic              web,
    output logic [DWIDTH-1:0] wb_data,
    input  logic [AWIDTH-1:0] chk_addr0,
    input  logic [AWIDTH-1:0] chk_addr1,
    output logic              pend0,
    output logic              pend1
);

    localparam logic [AWIDTH-1:0] X0 = AWIDTH'(X0_ADDR);

    logic                          a_full, a_empty, a_push, a_pop;
    logic                          l_full, l_empty, l_push, l_pop;
    logic [AWIDTH-1:0]             a_hd_addr, l_hd_addr;
    logic [DWIDTH-1:0]             a_hd_data, l_hd_data;
    logic [QDEPTH-1:0]             a_ev, l_ev;
    logic [QDEPTH-1:0][AWIDTH-1:0] a_ea, l_ea;
    logic                          conflict;
    logic                          hit0, hit1;

    assign bus.a_ready = rst && !a_full;
    assign bus.l_ready = rst && !l_full;
    assign a_push      = bus.a_valid && bus.a_ready;
    assign l_push      = bus.l_valid && bus.l_ready;

    // Same destination at both heads: A goes first so L's value lands last.
    assign conflict = !a_empty && !l_empty && (a_hd_addr == l_hd_addr);
    assign a_pop    = !a_empty;
    assign l_pop    = !l_empty && !conflict;

    wb_fifo #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(QDEPTH)) u_a_q (
        .clk(clk), .rst_n(rst),
        .push(a_push), .in_addr(bus.a_addr), .in_data(bus.a_data),
        .full(a_full), .pop(a_pop), .empty(a_empty),
        .head_addr(a_hd_addr), .head_data(a_hd_data),
        .ent_valid(a_ev), .ent_addr(a_ea)
    );

    wb_fifo #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(QDEPTH)) u_l_q (
        .clk(clk), .rst_n(rst),
        .push(l_push), .in_addr(bus.l_addr), .in_data(bus.l_data),
        .full(l_full), .pop(l_pop), .empty(l_empty),
        .head_addr(l_hd_addr), .head_data(l_hd_data),
        .ent_valid(l_ev), .ent_addr(l_ea)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wea     <= 1'b0;
            web     <= 1'b0;
            wa      <= '0;
            wb      <= '0;
            wa_data <= '0;
            wb_data <= '0;
        end else begin
            wea <= a_pop && (a_hd_addr != X0);
            web <= l_pop && (l_hd_addr != X0);
            if (a_pop) begin
                wa      <= a_hd_addr;
                wa_data <= a_hd_data;
            end
            if (l_pop) begin
                wb      <= l_hd_addr;
                wb_data <= l_hd_data;
            end
        end
    end

    always_comb begin
        hit0 = (wea && wa == chk_addr0) || (web && wb == chk_addr0);
        hit1 = (wea && wa == chk_addr1) || (web && wb == chk_addr1);
        for (int i = 0; i < QDEPTH; i++) begin
            if (a_ev[i] && a_ea[i] == chk_addr0) hit0 = 1'b1;
            if (l_ev[i] && l_ea[i] == chk_addr0) hit0 = 1'b1;
            if (a_ev[i] && a_ea[i] == chk_addr1) hit1 = 1'b1;
            if (l_ev[i] && l_ea[i] == chk_addr1) hit1 = 1'b1;
        end
    end

    assign pend0 = (chk_addr0 != X0) && hit0;
    assign pend1 = (chk_addr1 != X0) && hit1;

endmodule
